// File: rtl/lvdc_clock_pkg.sv
// Shared phase type, P/Q/R encodings and sizing constants for the clock-phase
// generator and its phase timer.
package lvdc_clock_pkg;

  typedef enum logic [1:0] {
    PH_W = 2'd0,
    PH_X = 2'd1,
    PH_Y = 2'd2,
    PH_Z = 2'd3
  } phase_t;

  // Encodings are packed as {P, Q, R}.
  localparam logic [2:0] PQR_W = 3'b101;
  localparam logic [2:0] PQR_X = 3'b011;
  localparam logic [2:0] PQR_Y = 3'b110;
  localparam logic [2:0] PQR_Z = 3'b000;

  localparam int BIT_WIDTH  = 4;
  localparam int TICK_WIDTH = 8;

  function automatic phase_t nextPhase(input phase_t phase);
    phase_t result;
    case (phase)
      PH_W:    result = PH_X;
      PH_X:    result = PH_Y;
      PH_Y:    result = PH_Z;
      default: result = PH_W;
    endcase
    return result;
  endfunction

  function automatic logic [2:0] phaseEncoding(input phase_t phase);
    logic [2:0] result;
    case (phase)
      PH_W:    result = PQR_W;
      PH_X:    result = PQR_X;
      PH_Y:    result = PQR_Y;
      default: result = PQR_Z;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/clock_phase_timer.sv
// Per-phase tick counter with terminal count, halt flag and RUN/STEP arbitration.
// o_halted and o_pastDead describe the state that takes effect at the coming edge.
module clock_phase_timer
  import lvdc_clock_pkg::*;
#(
  parameter int PHASE_TICKS = 4,
  parameter int DEAD_TICKS  = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_step,
  output logic o_advance,
  output logic o_halted,
  output logic o_pastDead
);

  localparam logic [TICK_WIDTH-1:0] LAST_TICK = TICK_WIDTH'(PHASE_TICKS - 1);
  localparam logic [TICK_WIDTH-1:0] DEAD_END  = TICK_WIDTH'(DEAD_TICKS);

  logic [TICK_WIDTH-1:0] r_tick;
  logic                  r_halted;
  logic                  r_stepMode;

  logic [TICK_WIDTH-1:0] w_tickNext;
  logic                  w_haltedNext;
  logic                  w_stepModeNext;
  logic                  w_advance;

  // A phase only ever ends at its last tick; halting parks there so a later
  // RUN or STEP can start the following phase on the very next edge.
  always_comb begin
    w_tickNext     = r_tick;
    w_haltedNext   = r_halted;
    w_stepModeNext = r_stepMode;
    w_advance      = 1'b0;
    if (r_halted) begin
      if (i_run) begin
        w_advance      = 1'b1;
        w_tickNext     = '0;
        w_haltedNext   = 1'b0;
        w_stepModeNext = 1'b0;
      end else if (i_step) begin
        w_advance      = 1'b1;
        w_tickNext     = '0;
        w_haltedNext   = 1'b0;
        w_stepModeNext = 1'b1;
      end
    end else if (r_tick != LAST_TICK) begin
      w_tickNext = r_tick + 1'b1;
    end else if (i_run && !r_stepMode) begin
      w_advance  = 1'b1;
      w_tickNext = '0;
    end else begin
      w_haltedNext   = 1'b1;
      w_stepModeNext = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tick     <= LAST_TICK;
      r_halted   <= 1'b1;
      r_stepMode <= 1'b0;
    end else begin
      r_tick     <= w_tickNext;
      r_halted   <= w_haltedNext;
      r_stepMode <= w_stepModeNext;
    end
  end

  assign o_advance  = w_advance;
  assign o_halted   = w_haltedNext;
  assign o_pastDead = (w_tickNext >= DEAD_END);

endmodule

// File: rtl/clock_generator.sv
// Four-phase W/X/Y/Z clock generator: phase FSM, registered P/Q/R pairs,
// BOP body enable, bit-time counter and BTEND pulse.
module clock_generator
  import lvdc_clock_pkg::*;
#(
  parameter int PHASE_TICKS = 4,
  parameter int DEAD_TICKS  = 1,
  parameter int NBITS       = 14
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_run,
  input  logic                 i_step,
  output logic                 o_cgpp,
  output logic                 o_cgppn,
  output logic                 o_cgqp,
  output logic                 o_cgqpn,
  output logic                 o_cgrp,
  output logic                 o_cgrpn,
  output logic                 o_bop,
  output logic [BIT_WIDTH-1:0] o_bit,
  output logic                 o_btend
);

  localparam logic [BIT_WIDTH-1:0] LAST_BIT = BIT_WIDTH'(NBITS - 1);

  phase_t               r_phase;
  logic [2:0]           r_pqr;
  logic [2:0]           r_pqrN;
  logic                 r_bop;
  logic [BIT_WIDTH-1:0] r_bit;
  logic                 r_btend;

  phase_t               w_phaseNext;
  logic [2:0]           w_pqrNext;
  logic [BIT_WIDTH-1:0] w_bitNext;
  logic                 w_btendNext;
  logic                 w_advance;
  logic                 w_halted;
  logic                 w_pastDead;

  clock_phase_timer #(
    .PHASE_TICKS(PHASE_TICKS),
    .DEAD_TICKS (DEAD_TICKS)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_run     (i_run),
    .i_step    (i_step),
    .o_advance (w_advance),
    .o_halted  (w_halted),
    .o_pastDead(w_pastDead)
  );

  // The bit count moves only on the Z->W boundary, so BTEND marks the first
  // W cycle of bit time 0 whether the block is free-running or stepping.
  always_comb begin
    w_phaseNext = r_phase;
    w_bitNext   = r_bit;
    w_btendNext = 1'b0;
    if (w_advance) begin
      w_phaseNext = nextPhase(r_phase);
      if (r_phase == PH_Z) begin
        w_bitNext   = (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
        w_btendNext = (w_bitNext == '0);
      end
    end
    w_pqrNext = phaseEncoding(w_phaseNext);
  end

  // BOP follows the timer's next tick, which is zero on any phase change,
  // so it is always low in the cycle the P/Q/R encoding moves.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase <= PH_Z;
      r_pqr   <= PQR_Z;
      r_pqrN  <= ~PQR_Z;
      r_bop   <= 1'b0;
      r_bit   <= LAST_BIT;
      r_btend <= 1'b0;
    end else begin
      r_phase <= w_phaseNext;
      r_pqr   <= w_pqrNext;
      r_pqrN  <= ~w_pqrNext;
      r_bop   <= ~w_halted & w_pastDead;
      r_bit   <= w_bitNext;
      r_btend <= w_btendNext;
    end
  end

  assign o_cgpp  = r_pqr[2];
  assign o_cgqp  = r_pqr[1];
  assign o_cgrp  = r_pqr[0];
  assign o_cgppn = r_pqrN[2];
  assign o_cgqpn = r_pqrN[1];
  assign o_cgrpn = r_pqrN[0];
  assign o_bop   = r_bop;
  assign o_bit   = r_bit;
  assign o_btend = r_btend;

endmodule

// File: tb/tb_clock_generator.sv
// Directed bench for clock_generator: default-parameter instance plus a
// PHASE_TICKS=2 instance sharing the same stimulus.
module tb_clock_generator;

  typedef struct {
    logic       reset;
    logic       run;
    logic       step;
    logic [2:0] pqr;
    logic       bop;
    logic [3:0] bitTime;
    logic       btend;
  } vector_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  logic step = 1'b0;

  logic cgpp, cgppn, cgqp, cgqpn, cgrp, cgrpn, bop, btend;
  logic [3:0] bitTime;
  logic cgpp2, cgppn2, cgqp2, cgqpn2, cgrp2, cgrpn2, bop2, btend2;
  logic [3:0] bitTime2;

  int checkCount = 0;
  int passCount  = 0;

  logic [2:0] encTable [4];
  vector_t    startupTable [17];

  always #5 clk = ~clk;

  clock_generator dut (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_step(step),
    .o_cgpp(cgpp), .o_cgppn(cgppn), .o_cgqp(cgqp), .o_cgqpn(cgqpn),
    .o_cgrp(cgrp), .o_cgrpn(cgrpn), .o_bop(bop), .o_bit(bitTime), .o_btend(btend)
  );

  clock_generator #(.PHASE_TICKS(2), .DEAD_TICKS(1), .NBITS(14)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_step(step),
    .o_cgpp(cgpp2), .o_cgppn(cgppn2), .o_cgqp(cgqp2), .o_cgqpn(cgqpn2),
    .o_cgrp(cgrp2), .o_cgrpn(cgrpn2), .o_bop(bop2), .o_bit(bitTime2), .o_btend(btend2)
  );

  task automatic applyStimulus(input logic rst, input logic rn, input logic stp);
    @(negedge clk);
    reset = rst;
    run   = rn;
    step  = stp;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int which, input logic [2:0] pqr,
                             input logic expBop, input logic [3:0] expBit, input logic expBtend);
    logic [11:0] actual;
    logic [11:0] expected;
    expected = {pqr, ~pqr, expBop, expBit, expBtend};
    if (which == 1)
      actual = {cgpp, cgqp, cgrp, cgppn, cgqpn, cgrpn, bop, bitTime, btend};
    else
      actual = {cgpp2, cgqp2, cgrp2, cgppn2, cgqpn2, cgrpn2, bop2, bitTime2, btend2};
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got pqr/n/bop/bit/btend=%b required %b", name, actual, expected);
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %b required %b", name, actual, expected);
  endtask

  initial begin
    logic [2:0] prevPqr2;
    encTable[0] = 3'b101;
    encTable[1] = 3'b011;
    encTable[2] = 3'b110;
    encTable[3] = 3'b000;

    for (int p = 0; p < 4; p++) begin
      for (int t = 0; t < 4; t++) begin
        startupTable[p*4+t] = '{1'b0, 1'b1, 1'b0, encTable[p], (t != 0), 4'd0,
                                (p == 0 && t == 0)};
      end
    end
    startupTable[16] = '{1'b0, 1'b1, 1'b0, 3'b101, 1'b0, 4'd1, 1'b0};

    // Reset state, then startup table (cycles 1..17)
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resetState", 1, 3'b000, 1'b0, 4'd13, 1'b0);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(startupTable[i].reset, startupTable[i].run, startupTable[i].step);
      checkOutput($sformatf("startup[%0d]", i), 1, startupTable[i].pqr,
                  startupTable[i].bop, startupTable[i].bitTime, startupTable[i].btend);
    end

    // Free run through the end of the word; BTEND again at cycle 225
    for (int c = 18; c <= 225; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("freeRun[%0d]", c), 1, encTable[((c-1)%16)/4],
                  ((c-1)%4) != 0, 4'(((c-1)/16)%14), c == 225);
    end

    // RUN dropped at tick 1 of X (cycle 230); X completes then holds
    for (int c = 226; c <= 230; c++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("xTick1", 1, 3'b011, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("xTick2", 1, 3'b011, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("xTick3", 1, 3'b011, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("xHalted", 1, 3'b011, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("xStillHalted", 1, 3'b011, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("resumeY", 1, 3'b110, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("resumeYTick1", 1, 3'b110, 1'b1, 4'd0, 1'b0);

    // Single step from halted Z; second STEP inside W is ignored
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resetMidY", 1, 3'b000, 1'b0, 4'd13, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idleZ", 1, 3'b000, 1'b0, 4'd13, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("stepW0", 1, 3'b101, 1'b0, 4'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("stepW1", 1, 3'b101, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stepW2", 1, 3'b101, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stepW3", 1, 3'b101, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stepHaltW", 1, 3'b101, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("stepHoldW", 1, 3'b101, 1'b0, 4'd0, 1'b0);

    // Run to BIT=5, tick 1 of Y, then reset and restart
    for (int c = 1; c <= 86; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (c == 77) checkOutput("reachBit5", 1, 3'b101, 1'b0, 4'd5, 1'b0);
    end
    checkOutput("midYBit5", 1, 3'b110, 1'b1, 4'd5, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("resetFromY", 1, 3'b000, 1'b0, 4'd13, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("restartW0", 1, 3'b101, 1'b0, 4'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("restartW1", 1, 3'b101, 1'b1, 4'd0, 1'b0);

    // PHASE_TICKS=2 instance: 8-cycle bit time, BOP 0,1, no BOP on change
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("fastReset", 2, 3'b000, 1'b0, 4'd13, 1'b0);
    prevPqr2 = 3'b000;
    for (int c = 1; c <= 17; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("fast[%0d]", c), 2, encTable[((c-1)%8)/2],
                  ((c-1)%2) != 0, 4'((c-1)/8), c == 1);
      if ({cgpp2, cgqp2, cgrp2} != prevPqr2)
        checkBit($sformatf("fastNoOverlap[%0d]", c), bop2, 1'b0);
      prevPqr2 = {cgpp2, cgqp2, cgrp2};
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
